data_mem_param: RTL and testbench
=================================

DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit RAM words (power of two, 16..4096).
REQ-002 Parameter BASE_ADDR, default 32'h1000, meaning the byte address that maps to RAM word 0.
REQ-003 Parameter LED_ADDR, default 32'h2000, meaning the byte address of the LED register.
REQ-004 Parameter CNT_ADDR, default 32'h2004, meaning the byte address of the read-only cycle counter.
REQ-005 Parameter LED_WIDTH, default 8, meaning the number of LED output bits (1..32).
REQ-006 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, reset, asynchronous and active-high.
REQ-008 Port req, input, 1, single-cycle request strobe, qualified by memread/memwrite.
REQ-009 Port addr, input, 32, byte address.
REQ-010 Port write_data, input, 32, store data, right-aligned.
REQ-011 Port memwrite / memread, input, 1 each, operation select; both high is an illegal request and is ignored.
REQ-012 Port sign_mask, input, 4: bit3 sign-extend; [2:0] 001 byte, 011 half, 111 word.
REQ-013 Port read_data, output, 32, load result.
REQ-014 Port clk_stall, output, 1, high while a request is in flight.
REQ-015 Port done, output, 1, one-cycle pulse on request completion.
REQ-016 Port led, output, LED_WIDTH, LED_REG[LED_WIDTH-1:0].
REQ-017 Port err, output, 1, present only under DMEM_RANGE_CHECK_EN.

Function
REQ-018 FSM states: IDLE, READ_BUFFER, READ, WRITE, MMIO.
REQ-019 IDLE: req with exactly one of memread/memwrite latches addr, write_data, sign_mask, and op; sets clk_stall=1; next state is MMIO if addr[31:2] equals LED_ADDR[31:2] or CNT_ADDR[31:2], else READ_BUFFER.
REQ-020 req outside IDLE is ignored, with no queuing.
REQ-021 READ_BUFFER: word_buf <= RAM[(addr_buf-BASE_ADDR)>>2] modulo DEPTH_WORDS; next state is READ or WRITE.
REQ-022 READ: read_data <= extracted value; clk_stall <= 0; done <= 1; return to IDLE; load latency is 3 edges from the req edge.
REQ-023 WRITE: RAM word <= merged word; clk_stall <= 0; done <= 1; return to IDLE.
REQ-024 Byte load selects lane addr[1:0]; half load selects lane addr[1], ignoring addr[0]; word load ignores addr[1:0]; zero- or sign-extend per bit3.
REQ-025 Byte store replaces lane addr[1:0]; half store replaces half addr[1]; word store replaces all; unaddressed lanes are preserved from word_buf.
REQ-026 MMIO LED write: LED_REG <= write_data (full 32 bits, all store sizes); done next edge; total 2 edges.
REQ-027 MMIO read: LED address returns LED_REG; CNT address returns the counter value sampled in the MMIO state, with no extension applied.
REQ-028 A write to CNT_ADDR is discarded and still completes with done.
REQ-029 Cycle counter is 32-bit, increments every clk, and wraps FFFFFFFF to 0.
REQ-030 read_data holds its value until the next load completes; stores do not alter it.
REQ-031 RAM contents are not cleared by rst; initial image comes from data.hex.

Reset
REQ-032 rst asserted: state=IDLE, clk_stall=0, done=0, read_data=0, LED_REG=0, counter=0, err=0, latched buffers=0.
REQ-033 rst mid-operation abandons the request with no RAM write; a WRITE state coincident with rst has no effect.
REQ-034 The first req is accepted on the first rising edge after rst deasserts.

Configuration
REQ-035 Macro DMEM_RANGE_CHECK_EN defined: a RAM access with addr_buf outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) skips the RAM, completes via READ (read_data=0) or WRITE (no store), and sets sticky err=1, cleared only by rst.
REQ-036 Macro undefined: err port is absent, and out-of-range addresses alias modulo DEPTH_WORDS.

Verification
REQ-037 Word store 32'hDEADBEEF to 0x1000, then half load signed 0x1002 -> read_data=FFFFDEAD, done exactly 3 edges after req.
REQ-038 Byte store 8'h5A to 0x1005 over word 32'h11223344 -> word load 0x1004 returns 0x11225A44.
REQ-039 Word store 0x000000A5 to LED_ADDR -> led=8'hA5 after 2 edges, clk_stall low, RAM unchanged.
REQ-040 rst pulse during READ_BUFFER of a store to 0x1008 -> RAM[2] unchanged, clk_stall=0, next req serviced normally.
REQ-041 With DMEM_RANGE_CHECK_EN, load 0x0FFC -> read_data=0, err=1, stays 1 after a later valid access.
REQ-042 Two CNT_ADDR loads 10 cycles apart -> difference of 10; counter preloaded near FFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/data_mem_param.sv
// Word-organised data RAM plus LED register and free-running cycle counter, behind a stalling request FSM.
// Optional macro DMEM_RANGE_CHECK_EN traps out-of-range RAM accesses onto a sticky err output.
module data_mem_param #(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
    parameter logic [31:0] LED_ADDR      = 32'h0000_2000,
    parameter logic [31:0] CNT_ADDR      = 32'h0000_2004,
    parameter int unsigned LED_WIDTH     = 8,
    parameter logic [31:0] CNT_RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [31:0]          addr,
    input  logic [31:0]          write_data,
    input  logic                 memwrite,
    input  logic                 memread,
    input  logic [3:0]           sign_mask,
    output logic [31:0]          read_data,
    output logic                 clk_stall,
    output logic                 done,
    output logic [LED_WIDTH-1:0] led
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic                 err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, READ_BUFFER, READ, WRITE, MMIO} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_buf_q, addr_buf_d;
    logic [31:0] wdata_buf_q, wdata_buf_d;
    logic [3:0]  mask_buf_q, mask_buf_d;
    logic        op_write_q, op_write_d;
    logic [31:0] word_buf_q, word_buf_d;
    logic [31:0] read_data_q, read_data_d;
    logic        clk_stall_q, clk_stall_d;
    logic        done_q, done_d;
    logic [31:0] led_reg_q, led_reg_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] mem_idx;
    logic        mem_we;
    logic        ram_ok;
    logic        accept;
    logic        mmio_hit;
    logic        led_sel;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] loaded;
    logic [31:0] merged;

    assign accept   = req & (memread ^ memwrite);
    assign mmio_hit = (addr[31:2] == LED_ADDR[31:2]) || (addr[31:2] == CNT_ADDR[31:2]);
    assign led_sel  = (addr_buf_q[31:2] == LED_ADDR[31:2]);

    // Subtracting only the low index bits gives the modulo-DEPTH aliasing for free.
    assign mem_idx = addr_buf_q[AW+1:2] - BASE_ADDR[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    logic [31:0] ram_off;
    assign ram_off = addr_buf_q - BASE_ADDR;
    assign ram_ok  = ram_off < (32'(DEPTH_WORDS) << 2);
`else
    assign ram_ok = 1'b1;
`endif

    assign lane_b = word_buf_q[{addr_buf_q[1:0], 3'b000} +: 8];
    assign lane_h = word_buf_q[{addr_buf_q[1], 4'b0000} +: 16];

    always_comb begin
        case (mask_buf_q[2:0])
            3'b001:  loaded = {{24{mask_buf_q[3] & lane_b[7]}}, lane_b};
            3'b011:  loaded = {{16{mask_buf_q[3] & lane_h[15]}}, lane_h};
            default: loaded = word_buf_q;
        endcase
    end

    always_comb begin
        merged = word_buf_q;
        case (mask_buf_q[2:0])
            3'b001:  merged[{addr_buf_q[1:0], 3'b000} +: 8] = wdata_buf_q[7:0];
            3'b011:  merged[{addr_buf_q[1], 4'b0000} +: 16] = wdata_buf_q[15:0];
            default: merged = wdata_buf_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_buf_q  <= '0;
            wdata_buf_q <= '0;
            mask_buf_q  <= '0;
            op_write_q  <= 1'b0;
            word_buf_q  <= '0;
            read_data_q <= '0;
            clk_stall_q <= 1'b0;
            done_q      <= 1'b0;
            led_reg_q   <= '0;
            cnt_q       <= CNT_RESET_VAL;
        end else begin
            state_q     <= state_d;
            addr_buf_q  <= addr_buf_d;
            wdata_buf_q <= wdata_buf_d;
            mask_buf_q  <= mask_buf_d;
            op_write_q  <= op_write_d;
            word_buf_q  <= word_buf_d;
            read_data_q <= read_data_d;
            clk_stall_q <= clk_stall_d;
            done_q      <= done_d;
            led_reg_q   <= led_reg_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (accept) state_d = mmio_hit ? MMIO : READ_BUFFER;
            READ_BUFFER: state_d = op_write_q ? WRITE : READ;
            READ:        state_d = IDLE;
            WRITE:       state_d = IDLE;
            MMIO:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_buf_d  = addr_buf_q;
        wdata_buf_d = wdata_buf_q;
        mask_buf_d  = mask_buf_q;
        op_write_d  = op_write_q;
        word_buf_d  = word_buf_q;
        read_data_d = read_data_q;
        clk_stall_d = clk_stall_q;
        done_d      = 1'b0;
        led_reg_d   = led_reg_q;
        cnt_d       = cnt_q + 32'd1;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_buf_d  = addr;
                    wdata_buf_d = write_data;
                    mask_buf_d  = sign_mask;
                    op_write_d  = memwrite;
                    clk_stall_d = 1'b1;
                end
            end
            READ_BUFFER: word_buf_d = mem[mem_idx];
            READ: begin
                read_data_d = ram_ok ? loaded : '0;
                clk_stall_d = 1'b0;
                done_d      = 1'b1;
            end
            WRITE: begin
                mem_we      = ram_ok;
                clk_stall_d = 1'b0;
                done_d      = 1'b1;
            end
            MMIO: begin
                // Stores to the counter address are dropped but still complete.
                if (op_write_q) begin
                    if (led_sel) led_reg_d = wdata_buf_q;
                end else begin
                    read_data_d = led_sel ? led_reg_q : cnt_q;
                end
                clk_stall_d = 1'b0;
                done_d      = 1'b1;
            end
            default: clk_stall_d = 1'b0;
        endcase
    end

    // state_q is reset asynchronously, so a WRITE cut short by rst never reaches the array.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= merged;
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (((state_q == READ) || (state_q == WRITE)) && !ram_ok) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`endif

    assign read_data = read_data_q;
    assign clk_stall = clk_stall_q;
    assign done      = done_q;
    assign led       = led_reg_q[LED_WIDTH-1:0];

endmodule

// File: tb/tb_data_mem_param.sv
// Bench for data_mem_param: transaction-level memory/MMIO model plus a per-cycle compare process.
module tb_data_mem_param;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] LEDA   = 32'h0000_2000;
    localparam logic [31:0] CNTA   = 32'h0000_2004;
    localparam int unsigned DEPTH  = 1024;
    localparam logic [31:0] W_INIT = 32'hFFFF_FFF0;

    logic        clk, rst;
    logic        req, memwrite, memread;
    logic [31:0] addr, write_data, read_data;
    logic [3:0]  sign_mask;
    logic        clk_stall, done;
    logic [7:0]  led;

    logic        w_req, w_memwrite, w_memread;
    logic [31:0] w_addr, w_write_data, w_read_data;
    logic [3:0]  w_sign_mask;
    logic        w_clk_stall, w_done;
    logic [7:0]  w_led;
`ifdef DMEM_RANGE_CHECK_EN
    logic        err, w_err;
`endif

    data_mem_param dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .write_data(write_data),
        .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
        .read_data(read_data), .clk_stall(clk_stall), .done(done), .led(led)
`ifdef DMEM_RANGE_CHECK_EN
        , .err(err)
`endif
    );

    data_mem_param #(.CNT_RESET_VAL(W_INIT)) dut_w (
        .clk(clk), .rst(rst), .req(w_req), .addr(w_addr), .write_data(w_write_data),
        .memwrite(w_memwrite), .memread(w_memread), .sign_mask(w_sign_mask),
        .read_data(w_read_data), .clk_stall(w_clk_stall), .done(w_done), .led(w_led)
`ifdef DMEM_RANGE_CHECK_EN
        , .err(w_err)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] cnt_m;
    logic [31:0] ram_m [DEPTH];
    logic [31:0] rd_m, led_reg_m;
    bit          err_m;
    bit          checking;

    bit          p_active, p_has_rd, p_has_led;
    int          p_start, p_len;
    logic [31:0] p_rd, p_led;
    logic        exp_stall, exp_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) cnt_m <= '0;
        else     cnt_m <= cnt_m + 32'd1;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a, input logic [3:0] m);
        logic [31:0] v;
        case (m[2:0])
            3'b001: begin
                v = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
                if (m[3] && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'b011: begin
                v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
                if (m[3] && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [31:0] wd, input logic [3:0] m);
        logic [31:0] msk;
        int          sh;
        case (m[2:0])
            3'b001:  begin sh = 8 * int'(a[1:0]); msk = 32'h0000_00FF << sh; end
            3'b011:  begin sh = 16 * int'(a[1]);  msk = 32'h0000_FFFF << sh; end
            default: begin sh = 0;                msk = 32'hFFFF_FFFF;       end
        endcase
        return (old & ~msk) | ((wd << sh) & msk);
    endfunction

    // Per-cycle compare against the transaction schedule recorded by op().
    always @(negedge clk) begin
        if (checking) begin
            exp_stall = 1'b0;
            exp_done  = 1'b0;
            if (rst) begin
                rd_m      = '0;
                led_reg_m = '0;
            end else if (p_active) begin
                if (cyc >= p_start && cyc < p_start + p_len - 1) exp_stall = 1'b1;
                if (cyc == p_start + p_len - 1) begin
                    exp_done = 1'b1;
                    if (p_has_rd)  rd_m = p_rd;
                    if (p_has_led) led_reg_m = p_led;
                end
            end
            chk("clk_stall", 32'(clk_stall), 32'(exp_stall));
            chk("done", 32'(done), 32'(exp_done));
            chk("read_data", read_data, rd_m);
            chk("led", 32'(led), 32'(led_reg_m[7:0]));
        end
    end

    task automatic junk();
        logic [2:0] r;
        r = 3'($urandom_range(0, 7));
        req = r[0]; memwrite = r[1]; memread = r[2];
        case ($urandom_range(0, 2))
            0:       addr = LEDA;
            1:       addr = CNTA;
            default: addr = BASE + 4 * $urandom_range(0, 15);
        endcase
        write_data = $urandom;
        sign_mask  = 4'($urandom_range(0, 15));
    endtask

    // Called at negedge+1; returns at negedge+1 of the done cycle.
    task automatic op(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        bit          mmio, is_cnt, in_rng;
        int unsigned idx;
        int          l;
        mmio   = (a[31:2] == LEDA[31:2]) || (a[31:2] == CNTA[31:2]);
        is_cnt = (a[31:2] == CNTA[31:2]);
        l      = mmio ? 2 : 3;
        p_has_rd = 0; p_has_led = 0; p_rd = '0; p_led = '0;
        if (!mmio) begin
            idx    = ((a - BASE) >> 2) % DEPTH;
            in_rng = 1;
`ifdef DMEM_RANGE_CHECK_EN
            in_rng = (a - BASE) < 4 * DEPTH;
`endif
            if (!in_rng) err_m = 1;
            if (wr) begin
                if (in_rng) ram_m[idx] = merge(ram_m[idx], a, wd, m);
            end else begin
                p_has_rd = 1;
                p_rd     = in_rng ? load_val(ram_m[idx], a, m) : '0;
            end
        end else if (!is_cnt) begin
            if (wr) begin p_has_led = 1; p_led = wd; end
            else    begin p_has_rd = 1;  p_rd = led_reg_m; end
        end else if (!wr) begin
            p_has_rd = 1;
        end
        p_start = cyc + 1; p_len = l; p_active = 1;
        req = 1'b1; memwrite = wr; memread = !wr; addr = a; write_data = wd; sign_mask = m;
        @(posedge clk); #1;
        if (mmio && is_cnt && !wr) p_rd = cnt_m;
        for (int k = 1; k < l; k++) begin
            junk();
            @(posedge clk); #1;
        end
        req = 1'b0; memwrite = 1'b0; memread = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic illegal();
        req = 1'b1; memwrite = 1'b1; memread = 1'b1; addr = LEDA; write_data = $urandom;
        @(posedge clk); #1;
        req = 1'b0; memwrite = 1'b0; memread = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic w_cnt_read(output logic [31:0] v);
        logic [31:0] exp;
        w_req = 1'b1; w_memread = 1'b1; w_addr = CNTA;
        @(posedge clk); #1;
        exp = cnt_m + W_INIT;
        w_req = 1'b0; w_memread = 1'b0;
        @(posedge clk); #1;
        chk("w_done", 32'(w_done), 32'd1);
        chk("w_stall", 32'(w_clk_stall), 32'd0);
        chk("w_led", 32'(w_led), 32'd0);
        chk("w_cnt_model", w_read_data, exp);
`ifdef DMEM_RANGE_CHECK_EN
        chk("w_err", 32'(w_err), 32'd0);
`endif
        v = w_read_data;
        @(negedge clk); #1;
    endtask

    initial begin
        logic [31:0] v, c1, c2, a, wd;
        logic [3:0]  m;
        int          sel;
        rst = 1'b0; req = 1'b0; memwrite = 1'b0; memread = 1'b0;
        addr = '0; write_data = '0; sign_mask = '0;
        w_req = 1'b0; w_memwrite = 1'b0; w_memread = 1'b0;
        w_addr = '0; w_write_data = '0; w_sign_mask = '0;
        p_active = 0; err_m = 0; rd_m = '0; led_reg_m = '0;
        #1 rst = 1'b1;
        checking = 1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        chk("rst_read_data", read_data, 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_stall", 32'(clk_stall), 32'd0);
`ifdef DMEM_RANGE_CHECK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif

        op(0, CNTA, '0, 4'b0111);
        chk("cnt_first_after_rst", read_data, 32'd1);
        w_cnt_read(v);
        chk("cnt_pre_wrap", v, 32'hFFFF_FFF3);
        idle(20);
        w_cnt_read(v);
        chk("cnt_wrapped", v, 32'h0000_0009);

        op(0, CNTA, '0, 4'b0111);
        c1 = read_data;
        idle(8);
        op(0, CNTA, '0, 4'b0111);
        c2 = read_data;
        chk("cnt_delta_10", c2 - c1, 32'd10);

        for (int w = 0; w < 16; w++) op(1, BASE + 4 * w, $urandom, 4'b0111);

        op(1, BASE, 32'hDEAD_BEEF, 4'b0111);
        op(0, BASE + 2, '0, 4'b1011);
        chk("half_signed_done", 32'(done), 32'd1);
        chk("half_signed_data", read_data, 32'hFFFF_DEAD);

        op(1, BASE + 4, 32'h1122_3344, 4'b0111);
        op(1, BASE + 5, 32'hFFFF_FF5A, 4'b0001);
        op(0, BASE + 4, '0, 4'b0111);
        chk("byte_merge", read_data, 32'h1122_5A44);

        op(1, LEDA, 32'h0000_00A5, 4'b0111);
        chk("led_a5", 32'(led), 32'h0000_00A5);
        chk("led_stall_low", 32'(clk_stall), 32'd0);
        op(0, BASE + 4, '0, 4'b0111);
        chk("ram_after_led", read_data, 32'h1122_5A44);

        op(1, BASE + 8, 32'h0BAD_CAFE, 4'b0111);
        p_active = 0;
        req = 1'b1; memwrite = 1'b1; memread = 1'b0;
        addr = BASE + 8; write_data = 32'h1234_5678; sign_mask = 4'b0111;
        @(posedge clk); #1;
        req = 1'b0; memwrite = 1'b0;
        rst = 1'b1;
        err_m = 0;
        #1 chk("rst_mid_stall", 32'(clk_stall), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        op(0, BASE + 8, '0, 4'b0111);
        chk("ram_survives_rst", read_data, 32'h0BAD_CAFE);

`ifdef DMEM_RANGE_CHECK_EN
        op(0, BASE, '0, 4'b0111);
        op(0, 32'h0000_0FFC, '0, 4'b0111);
        chk("oor_read_zero", read_data, 32'd0);
        chk("oor_err_set", 32'(err), 32'd1);
        op(0, BASE + 4, '0, 4'b0111);
        chk("err_sticky", 32'(err), 32'd1);
`endif

        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 11));
            case ($urandom_range(0, 2))
                0:       m = 4'b0001;
                1:       m = 4'b0011;
                default: m = 4'b0111;
            endcase
            m[3] = 1'($urandom_range(0, 1));
            a  = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
`ifndef DMEM_RANGE_CHECK_EN
            if ($urandom_range(0, 3) == 0) a = a + 32'h0000_2000;
`endif
            wd = $urandom;
            if (sel <= 3)       op(1, a, wd, m);
            else if (sel <= 7)  op(0, a, '0, m);
            else if (sel == 8)  op(1, LEDA, wd, m);
            else if (sel == 9)  op(0, LEDA, '0, m);
            else if (sel == 10) op(1'($urandom_range(0, 1)), CNTA, wd, m);
            else                illegal();
        end

`ifdef DMEM_RANGE_CHECK_EN
        chk("err_final", 32'(err), 32'(err_m));
`endif
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
